// File: rtl/mpdiv_pkg.sv
// Shared types and constants for the multi-phase divider dither controller.
package mpdiv_pkg;

  localparam int NPH         = 8;
  localparam int CODE_W      = 6;
  localparam int LFSR_W      = 9;
  localparam int LFSR_TAP_A  = 9;
  localparam int LFSR_TAP_B  = 5;
  localparam logic [LFSR_W-1:0] LFSR_SEED = 9'd1;

  typedef enum logic [1:0] {
    MODE_OFF   = 2'd0,
    MODE_FIXED = 2'd1,
    MODE_RAND  = 2'd2,
    MODE_SWEEP = 2'd3
  } mode_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PEND = 2'd1,
    ST_ACK  = 2'd2
  } state_t;

endpackage

// File: rtl/mpdiv_dither_ctrl_if.sv
// Configuration handshake, run enable and per-phase code bus of the dither controller.
interface mpdiv_dither_ctrl_if;
  import mpdiv_pkg::*;

  logic                    en;
  logic                    cfg_req;
  mode_t                   cfg_mode;
  logic [CODE_W-1:0]       cfg_code;
  logic                    cfg_ack;
  logic [2:0]              ph_cnt;
  logic [NPH-1:0]          ph_oh;
  logic [NPH*CODE_W-1:0]   dly_code;
  logic                    code_vld;
  logic                    busy;

  modport master (
    output en, cfg_req, cfg_mode, cfg_code,
    input  cfg_ack, ph_cnt, ph_oh, dly_code, code_vld, busy
  );

  modport slave (
    input  en, cfg_req, cfg_mode, cfg_code,
    output cfg_ack, ph_cnt, ph_oh, dly_code, code_vld, busy
  );

endinterface

// File: rtl/mpdiv_lfsr9.sv
// 9-bit XNOR LFSR; bits are numbered 9..1 so the delay code taps are lfsr[6:1].
module mpdiv_lfsr9
  import mpdiv_pkg::*;
(
  input  logic              clk,
  input  logic              narst,
  input  logic              step,
  input  logic              load,
  input  logic [LFSR_W:1]   seed,
  output logic [LFSR_W:1]   lfsr
);

  // load wins over step so a new RAND configuration always starts from the seed
  always_ff @(posedge clk or negedge narst) begin
    if (!narst) begin
      lfsr <= LFSR_SEED;
    end else if (load) begin
      lfsr <= seed;
    end else if (step) begin
      lfsr <= {lfsr[LFSR_W-1:1], lfsr[LFSR_TAP_A] ~^ lfsr[LFSR_TAP_B]};
    end
  end

endmodule

// File: rtl/mpdiv_dither_ctrl.sv
// Round-robin per-phase dither code generator with frame-aligned configuration apply.
// state | meaning
// IDLE  | no request outstanding, shadow registers open
// PEND  | request latched, waiting for frame boundary (or apply at once when EN=0)
// ACK   | configuration applied, CFG_ACK high until CFG_REQ drops
module mpdiv_dither_ctrl
  import mpdiv_pkg::*;
(
  input  logic               clk,
  input  logic               narst,
  mpdiv_dither_ctrl_if.slave bus
);

  state_t                state_q, state_d;
  mode_t                 act_mode, sh_mode;
  logic [CODE_W-1:0]     act_code, sh_code, ramp, code_c;
  logic [2:0]            ph_cnt;
  logic [NPH-1:0]        ph_oh;
  logic [NPH*CODE_W-1:0] dly_q;
  logic                  code_vld, vld_wait, vld_fill;
  logic                  apply, take_req, wr_last;
  logic [LFSR_W:1]       lfsr;

  assign wr_last = bus.en && (ph_cnt == 3'(NPH - 1));

  always_comb begin
    state_d  = state_q;
    apply    = 1'b0;
    take_req = 1'b0;
    case (state_q)
      ST_IDLE: if (bus.cfg_req) begin
        take_req = 1'b1;
        state_d  = ST_PEND;
      end
      ST_PEND: if (!bus.en || ph_cnt == 3'(NPH - 1)) begin
        apply   = 1'b1;
        state_d = ST_ACK;
      end
      ST_ACK: if (!bus.cfg_req) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    code_c = '0;
    case (act_mode)
      MODE_FIXED: code_c = act_code;
      MODE_RAND:  code_c = lfsr[CODE_W:1];
      MODE_SWEEP: code_c = ramp + CODE_W'(ph_cnt);
      default:    code_c = '0;
    endcase
  end

  mpdiv_lfsr9 u_lfsr (
    .clk   (clk),
    .narst (narst),
    .step  (bus.en && act_mode == MODE_RAND),
    .load  (apply && sh_mode == MODE_RAND),
    .seed  (LFSR_SEED),
    .lfsr  (lfsr)
  );

  always_ff @(posedge clk or negedge narst) begin
    if (!narst) begin
      state_q  <= ST_IDLE;
      sh_mode  <= MODE_OFF;
      sh_code  <= '0;
      act_mode <= MODE_OFF;
      act_code <= '0;
      ramp     <= '0;
      ph_cnt   <= '0;
      ph_oh    <= NPH'(1);
      dly_q    <= '0;
      code_vld <= 1'b0;
      vld_wait <= 1'b0;
      vld_fill <= 1'b0;
    end else begin
      state_q <= state_d;
      if (take_req) begin
        sh_mode <= bus.cfg_mode;
        sh_code <= bus.cfg_code;
      end
      if (apply) begin
        act_mode <= sh_mode;
        act_code <= sh_code;
      end
      if (apply && sh_mode == MODE_SWEEP) begin
        ramp <= '0;
      end else if (wr_last && act_mode == MODE_SWEEP) begin
        ramp <= ramp + 1'b1;
      end
      if (bus.en) begin
        dly_q[ph_cnt*CODE_W +: CODE_W] <= code_c;
        ph_cnt <= ph_cnt + 3'd1;
        ph_oh  <= {ph_oh[NPH-2:0], ph_oh[NPH-1]};
      end
      // valid only after a full 0..7 frame has been written under the new mode
      if (apply) begin
        code_vld <= 1'b0;
        vld_wait <= 1'b1;
        vld_fill <= 1'b0;
      end else if (bus.en) begin
        if (vld_wait && ph_cnt == 3'd0) begin
          vld_wait <= 1'b0;
          vld_fill <= 1'b1;
        end
        if (vld_fill && wr_last) begin
          code_vld <= 1'b1;
          vld_fill <= 1'b0;
        end
      end
    end
  end

  assign bus.cfg_ack  = (state_q == ST_ACK);
  assign bus.busy     = (state_q == ST_PEND);
  assign bus.ph_cnt   = ph_cnt;
  assign bus.ph_oh    = ph_oh;
  assign bus.dly_code = dly_q;
  assign bus.code_vld = code_vld;

endmodule

// File: tb/tb_mpdiv_dither_ctrl.sv
// Directed bench for mpdiv_dither_ctrl: vector table for the FIXED handshake, sequences for RAND/SWEEP/EN=0/reset.
module tb_mpdiv_dither_ctrl;
  import mpdiv_pkg::*;

  logic clk = 1'b0;
  logic narst;
  always #5 clk = ~clk;

  mpdiv_dither_ctrl_if bus();
  mpdiv_dither_ctrl dut (.clk(clk), .narst(narst), .bus(bus));

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic        en;
    logic        req;
    mode_t       mode;
    logic [5:0]  code;
    logic [2:0]  ph;
    logic [47:0] dly;
    logic        vld;
    logic        ack;
    logic        busy;
  } vec_t;

  vec_t tbl[24];
  logic [5:0] rnd_exp[8];

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [47:0] act, input logic [47:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [47:0] fill(input int n, input logic [5:0] c);
    logic [47:0] r = '0;
    for (int k = 0; k < n; k++) r[k*6 +: 6] = c;
    return r;
  endfunction

  function automatic logic [47:0] sweep(input int base);
    logic [47:0] r = '0;
    for (int k = 0; k < 8; k++) r[k*6 +: 6] = 6'((base + k) % 64);
    return r;
  endfunction

  task automatic chk_reset(input string tag);
    chk({tag, "_ph"},   48'(bus.ph_cnt),   48'(0));
    chk({tag, "_oh"},   48'(bus.ph_oh),    48'(8'h01));
    chk({tag, "_dly"},  bus.dly_code,      48'(0));
    chk({tag, "_vld"},  48'(bus.code_vld), 48'(0));
    chk({tag, "_ack"},  48'(bus.cfg_ack),  48'(0));
    chk({tag, "_busy"}, 48'(bus.busy),     48'(0));
  endtask

  task automatic wait_ack(input string tag, input int maxc, output int n);
    n = 0;
    while (!bus.cfg_ack && n < maxc) begin
      tick;
      n++;
    end
    chk({tag, "_ack_seen"}, 48'(bus.cfg_ack), 48'(1));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not reach its end");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    logic [47:0] rfr;

    narst        = 1'b0;
    bus.en       = 1'b0;
    bus.cfg_req  = 1'b0;
    bus.cfg_mode = MODE_OFF;
    bus.cfg_code = '0;

    for (int i = 0; i < 24; i++) begin
      tbl[i].en   = 1'b1;
      tbl[i].req  = 1'b0;
      tbl[i].mode = MODE_OFF;
      tbl[i].code = '0;
      tbl[i].ph   = 3'(i + 1);
      tbl[i].dly  = '0;
      tbl[i].vld  = 1'b0;
      tbl[i].ack  = 1'b0;
      tbl[i].busy = 1'b0;
      if (i >= 11 && i <= 15) begin
        tbl[i].req  = 1'b1;
        tbl[i].mode = (i == 11) ? MODE_FIXED : MODE_SWEEP;
        tbl[i].code = (i == 11) ? 6'h2A : 6'h15;
        tbl[i].busy = (i < 15);
        tbl[i].ack  = (i == 15);
      end
      if (i >= 16) begin
        tbl[i].dly = fill(i - 15, 6'h2A);
        tbl[i].vld = (i == 23);
      end
    end
    rnd_exp = '{6'd1, 6'd3, 6'd7, 6'd15, 6'd31, 6'd62, 6'd60, 6'd56};

    tick;
    tick;
    chk_reset("rst0");
    narst = 1'b1;

    for (int i = 0; i < 24; i++) begin
      bus.en       = tbl[i].en;
      bus.cfg_req  = tbl[i].req;
      bus.cfg_mode = tbl[i].mode;
      bus.cfg_code = tbl[i].code;
      tick;
      chk($sformatf("v%0d_ph", i),   48'(bus.ph_cnt),   48'(tbl[i].ph));
      chk($sformatf("v%0d_oh", i),   48'(bus.ph_oh),    48'(8'h01 << tbl[i].ph));
      chk($sformatf("v%0d_dly", i),  bus.dly_code,      tbl[i].dly);
      chk($sformatf("v%0d_vld", i),  48'(bus.code_vld), 48'(tbl[i].vld));
      chk($sformatf("v%0d_ack", i),  48'(bus.cfg_ack),  48'(tbl[i].ack));
      chk($sformatf("v%0d_busy", i), 48'(bus.busy),     48'(tbl[i].busy));
    end

    // RAND: request at PH_CNT=0 waits a full frame
    bus.cfg_req  = 1'b1;
    bus.cfg_mode = MODE_RAND;
    wait_ack("rand", 12, n);
    chk("rand_ack_lat", 48'(n), 48'(8));
    chk("rand_ack_ph", 48'(bus.ph_cnt), 48'(0));
    bus.cfg_req = 1'b0;
    tick;
    chk("rand_s0", 48'(bus.dly_code[5:0]), 48'(rnd_exp[0]));
    chk("rand_ack_drop", 48'(bus.cfg_ack), 48'(0));
    tick;
    chk("rand_s1", 48'(bus.dly_code[11:6]), 48'(rnd_exp[1]));
    bus.en = 1'b0;
    repeat (3) tick;
    chk("rand_hold_ph", 48'(bus.ph_cnt), 48'(2));
    chk("rand_hold_s2", 48'(bus.dly_code[17:12]), 48'(6'h2A));
    bus.en = 1'b1;
    tick;
    chk("rand_s2", 48'(bus.dly_code[17:12]), 48'(rnd_exp[2]));
    tick;
    chk("rand_s3", 48'(bus.dly_code[23:18]), 48'(rnd_exp[3]));
    chk("rand_vld_early", 48'(bus.code_vld), 48'(0));
    tick;
    chk("rand_s4", 48'(bus.dly_code[29:24]), 48'(rnd_exp[4]));
    repeat (3) tick;
    rfr = '0;
    for (int k = 0; k < 8; k++) rfr[k*6 +: 6] = rnd_exp[k];
    chk("rand_frame", bus.dly_code, rfr);
    chk("rand_vld", 48'(bus.code_vld), 48'(1));

    // SWEEP through a full ramp wrap
    bus.cfg_req  = 1'b1;
    bus.cfg_mode = MODE_SWEEP;
    wait_ack("sweep", 12, n);
    chk("sweep_ack_lat", 48'(n), 48'(8));
    bus.cfg_req = 1'b0;
    repeat (8) tick;
    chk("sweep_f0", bus.dly_code, sweep(0));
    chk("sweep_f0_vld", 48'(bus.code_vld), 48'(1));
    repeat (8) tick;
    chk("sweep_f1", bus.dly_code, sweep(1));
    for (int f = 2; f < 63; f++) repeat (8) tick;
    repeat (8) tick;
    chk("sweep_f63", bus.dly_code, sweep(63));
    chk("sweep_f63_s7", 48'(bus.dly_code[47:42]), 48'(6));
    repeat (8) tick;
    chk("sweep_f64", bus.dly_code, sweep(0));

    // request with EN=0 applies on the next cycle; held REQ must not re-apply
    bus.en       = 1'b0;
    bus.cfg_req  = 1'b1;
    bus.cfg_mode = MODE_FIXED;
    bus.cfg_code = 6'h15;
    tick;
    chk("en0_busy", 48'(bus.busy), 48'(1));
    chk("en0_ack_c1", 48'(bus.cfg_ack), 48'(0));
    tick;
    chk("en0_ack_c2", 48'(bus.cfg_ack), 48'(1));
    bus.en       = 1'b1;
    bus.cfg_mode = MODE_RAND;
    bus.cfg_code = 6'h00;
    for (int i = 0; i < 8; i++) begin
      tick;
      chk($sformatf("hold%0d_ack", i), 48'(bus.cfg_ack), 48'(1));
      chk($sformatf("hold%0d_busy", i), 48'(bus.busy), 48'(0));
    end
    chk("hold_frame", bus.dly_code, fill(8, 6'h15));
    chk("hold_vld", 48'(bus.code_vld), 48'(1));
    bus.cfg_req = 1'b0;
    tick;
    chk("hold_ack_drop", 48'(bus.cfg_ack), 48'(0));

    // async reset while PEND at PH_CNT=5
    tick;
    tick;
    bus.cfg_req  = 1'b1;
    bus.cfg_mode = MODE_SWEEP;
    tick;
    tick;
    chk("pend_busy", 48'(bus.busy), 48'(1));
    chk("pend_ph", 48'(bus.ph_cnt), 48'(5));
    #2;
    narst = 1'b0;
    #1;
    chk_reset("rst1");
    bus.cfg_req = 1'b0;
    tick;
    narst = 1'b1;
    repeat (16) tick;
    chk("post_rst_dly", bus.dly_code, 48'(0));
    chk("post_rst_vld", 48'(bus.code_vld), 48'(0));
    chk("post_rst_busy", 48'(bus.busy), 48'(0));
    chk("post_rst_ack", 48'(bus.cfg_ack), 48'(0));
    chk("post_rst_ph", 48'(bus.ph_cnt), 48'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mpdiv_dither_ctrl.md
# mpdiv_dither_ctrl

Sequencing controller for the 8-phase multi-phase divider's clock-dither path. It walks the eight output phases round-robin and produces a registered 6-bit delay code per phase from one of four modes: off, fixed, LFSR-random or sweep. Mode changes are taken through a 4-phase request/acknowledge handshake and applied only on a frame boundary, so a frame of eight phases never mixes codes from two configurations. It sits between the FOD configuration logic and the per-phase dither delay lines of the divider.

## Interface
- NPH, 8: number of phases; fixed at 8; the phase counter is 3 bits.
- CODE_W, 6: delay code width (LSB = t_res).
- LFSR_SEED, 9'd1: LFSR value on reset and on entry to RAND.
- CLK  in  1: divider input clock. One clock domain only.
- NARST  in  1: reset, asynchronous, active-low.
- EN  in  1: run enable. While low, the phase counter, LFSR and ramp hold.
- CFG_REQ  in  1: configuration request, 4-phase handshake.
- CFG_MODE  in  2: 0 OFF, 1 FIXED, 2 RAND, 3 SWEEP.
- CFG_CODE  in  6: code used in FIXED mode.
- CFG_ACK  out  1: configuration acknowledge.
- PH_CNT  out  3: phase slot updated on this cycle.
- PH_OH  out  8: one-hot of PH_CNT.
- DLY_CODE  out  48: slot k is DLY_CODE[6k+5:6k].
- CODE_VLD  out  1: all 8 slots have been written under the current mode.
- BUSY  out  1: a configuration is pending (FSM in PEND).

## Operation
- Reset values: PH_CNT=0, PH_OH=8'h01, DLY_CODE=0, CODE_VLD=0, CFG_ACK=0, BUSY=0. Internal state resets to: active mode OFF, active code 0, LFSR=LFSR_SEED, ramp=0, FSM in IDLE.
- Each cycle with EN=1:
  - slot PH_CNT is written with code c;
  - PH_CNT increments, wrapping 7→0;
  - a frame is PH_CNT 0..7.
- Code c by mode:
  - OFF: c = 0.
  - FIXED: c = active code.
  - RAND: c = lfsr[6:1]. After the write, lfsr <= {lfsr[8:1], lfsr[9] ~^ lfsr[5]}.
  - SWEEP: c = (ramp + PH_CNT) mod 64. ramp increments by 1, mod 64, on each write where PH_CNT==7.
- Configuration FSM:
  - IDLE: when CFG_REQ=1, latch CFG_MODE and CFG_CODE into the shadow registers and go to PEND. BUSY=1 while in PEND.
  - PEND, EN=1: on the cycle where PH_CNT==7, the active mode and code take the shadow values, effective from the write at PH_CNT=0. Go to ACK.
  - PEND, EN=0: apply on the next cycle and go to ACK.
  - Applying a configuration: CODE_VLD clears; LFSR reloads LFSR_SEED if the new mode is RAND; ramp clears to 0 if the new mode is SWEEP.
  - ACK: CFG_ACK=1. Go to IDLE when CFG_REQ=0; CFG_ACK drops in the same transition.
- CFG_MODE and CFG_CODE are sampled only on IDLE→PEND. Changes to them afterwards are ignored until the next request.
- CODE_VLD sets on the write at PH_CNT==7 of the first complete frame after apply. It stays set until the next apply.
- The write at PH_CNT==7 and the apply on that same edge do not conflict: slot 7 takes the old-mode code, and the new mode begins at slot 0.
- NARST assertion mid-frame or mid-handshake: immediate return to all reset values, and CFG_ACK=0.

## Timing
- Each slot is registered. The code written at the edge with PH_CNT==k appears on DLY_CODE slot k the cycle after that edge. There is no combinational path from inputs to outputs.
- PH_CNT and PH_OH are registered and always consistent with each other.
- CFG_REQ rise to CFG_ACK rise:
  - minimum 2 cycles (request sampled when PH_CNT==6);
  - maximum 9 cycles with EN=1;
  - 2 cycles with EN=0.
- Latency from apply to CODE_VLD: 8 EN-cycles.

## Structure
- Shared package mpdiv_pkg holds:
  - the mode enum (OFF, FIXED, RAND, SWEEP);
  - the FSM state enum (IDLE, PEND, ACK);
  - NPH, CODE_W, LFSR_SEED, and the LFSR tap constants (9, 5).
- One sub-module, mpdiv_lfsr9: 9-bit XNOR LFSR with ports step, load, and a seed input. It is instantiated once.
- The ramp, the slot array and the FSM live in the top module.

## Test plan
- Reset, then release with EN=1 and no request → PH_CNT runs 0,1,…,7,0; DLY_CODE stays 48'h0; CODE_VLD stays 0.
- Request FIXED with code 6'h2A, raised when PH_CNT=3 → CFG_ACK rises 5 cycles later; after one more frame DLY_CODE = {8{6'h2A}} and CODE_VLD=1.
- Request RAND → slot codes 0..4 of the first frame are 1, 3, 7, 15, 31. Drop EN for 3 cycles mid-frame and the sequence resumes without skipping a value.
- Request SWEEP → frame 0 slots = 0..7, frame 1 = 1..8. After 64 frames the ramp wraps, and slot 7 = (63+7) mod 64 = 6 in frame 63.
- Raise CFG_REQ with EN=0 → ACK arrives 2 cycles later. Hold CFG_REQ high → ACK stays high and no second apply occurs. Drop CFG_REQ → ACK drops.
- Pulse NARST low while in PEND at PH_CNT=5 → all outputs return to reset values immediately and the pending configuration is discarded.
